// File: rtl/uart2wb_burst_if.sv
// Wishbone master-side bundle used by the UART burst bridge.
// The _o/_i suffixes follow the master's point of view.
interface uart2wb_burst_if #(
    parameter int unsigned AW = 24
) ();
    logic          cyc_o;
    logic          stb_o;
    logic [AW-1:0] adr_o;
    logic [7:0]    dat_o;
    logic          we_o;
    logic          ack_i;
    logic          err_i;
    logic          rty_i;
    logic [7:0]    dat_i;

    modport master (
        output cyc_o, stb_o, adr_o, dat_o, we_o,
        input  ack_i, err_i, rty_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o, dat_o, we_o,
        output ack_i, err_i, rty_i, dat_i
    );
endinterface

// File: rtl/uart2wb_burst.sv
// UART command parser driving single or burst Wishbone cycles.
// It returns read data and a status byte over UART TX.
module uart2wb_burst #(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned ADDR_BYTES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            uart_rxd,
    output logic            uart_txd,
    output logic            busy_o,
    uart2wb_burst_if.master wb
);
    localparam int unsigned AW = 8 * ADDR_BYTES;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BitLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BitHalf = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    AbLast  = 2'(ADDR_BYTES - 1);

    typedef enum logic [2:0] {
        StHeader, StAddr, StWrData, StRdCycle, StRdTx, StStatusTx
    } state_e;

    state_e state_q, state_d;

    logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_sh_q, hold_q;
    logic          hold_vld_q;
    logic          tx_busy_q, txd_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_sh_q;
    logic          we_q, fixed_q, wbwe_q, cyc_q;
    logic [6:0]    xfer_q;
    logic [1:0]    abyte_q, fail_q, code;
    logic [AW-1:0] adr_q;
    logic [7:0]    dat_q, rdata_q, tx_byte;
    logic [TW-1:0] tmo_q;
    logic [5:0]    nack_q;
    logic          rx_stop, rx_ferr, rx_accept, consume, tx_load, tx_done, term;

    assign rx_stop = rx_busy_q && (rx_bit_q == 4'd9) && (rx_cnt_q == BitLast);
    assign rx_ferr = rx_stop && !rxd_s2_q;
    assign tx_done = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BitLast);
    assign term    = cyc_q && (wb.ack_i || wb.err_i || wb.rty_i || (tmo_q == TmoLast));

    always_comb begin
        code = 2'd3;
        if (wb.err_i)      code = 2'd1;
        else if (wb.rty_i) code = 2'd2;
        else if (wb.ack_i) code = 2'd0;
    end

    // RX: start bit re-checked at mid-bit, then sampled every bit period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_s3_q   <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            rxd_s1_q <= uart_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
            if (!rx_busy_q) begin
                if (rxd_s3_q && !rxd_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_bit_q == 4'd0) begin
                if (rx_cnt_q == BitHalf) begin
                    rx_cnt_q <= '0;
                    if (rxd_s2_q) rx_busy_q <= 1'b0;
                    else          rx_bit_q  <= 4'd1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            end else if (rx_cnt_q == BitLast) begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                end else begin
                    rx_sh_q  <= {rxd_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
            if (!rx_accept || consume) hold_vld_q <= 1'b0;
            if (rx_stop && rxd_s2_q && rx_accept) begin
                hold_q     <= rx_sh_q;
                hold_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
            txd_q     <= 1'b1;
        end else if (tx_load) begin
            tx_busy_q <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= {1'b1, tx_byte};
            txd_q     <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BitLast) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                    txd_q    <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StHeader;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHeader:   if (consume) state_d = StAddr;
            StAddr: begin
                if (rx_ferr) state_d = StHeader;
                else if (consume && abyte_q == AbLast) state_d = we_q ? StWrData : StRdCycle;
            end
            StWrData: begin
                if (rx_ferr) state_d = StHeader;
                else if (xfer_q == 7'd0 && !cyc_q) state_d = StStatusTx;
            end
            StRdCycle:  if (term || (!cyc_q && fail_q != 2'd0)) state_d = StRdTx;
            StRdTx:     if (tx_done) state_d = (xfer_q == 7'd1) ? StStatusTx : StRdCycle;
            StStatusTx: if (tx_done) state_d = StHeader;
            default:    state_d = StHeader;
        endcase
    end

    always_comb begin
        rx_accept = (state_q == StHeader) || (state_q == StAddr) || (state_q == StWrData);
        consume   = hold_vld_q && ((state_q == StHeader) || (state_q == StAddr) ||
                    ((state_q == StWrData) && !cyc_q && xfer_q != 7'd0));
        tx_load   = ((state_q == StRdTx) || (state_q == StStatusTx)) && !tx_busy_q;
        tx_byte   = (state_q == StStatusTx) ? {nack_q, fail_q} : rdata_q;
        busy_o    = (state_q != StHeader);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            fixed_q <= 1'b0;
            xfer_q  <= '0;
            abyte_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            wbwe_q  <= 1'b0;
            cyc_q   <= 1'b0;
            tmo_q   <= '0;
            fail_q  <= '0;
            nack_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StHeader: if (consume) begin
                    we_q    <= hold_q[7];
                    fixed_q <= hold_q[6];
                    xfer_q  <= {1'b0, hold_q[5:0]} + 7'd1;
                    abyte_q <= '0;
                    fail_q  <= '0;
                    nack_q  <= '0;
                end
                StAddr: if (consume) begin
                    adr_q[8*abyte_q +: 8] <= hold_q;
                    abyte_q <= abyte_q + 2'd1;
                end
                StWrData: if (consume) begin
                    xfer_q <= xfer_q - 7'd1;
                    // after a failure the byte is swallowed without a cycle
                    if (fail_q == 2'd0) begin
                        cyc_q  <= 1'b1;
                        wbwe_q <= 1'b1;
                        dat_q  <= hold_q;
                        tmo_q  <= '0;
                    end
                end
                StRdCycle: if (!cyc_q) begin
                    if (fail_q == 2'd0) begin
                        cyc_q  <= 1'b1;
                        wbwe_q <= 1'b0;
                        tmo_q  <= '0;
                    end else begin
                        rdata_q <= '0;
                    end
                end
                StRdTx: if (tx_done) xfer_q <= xfer_q - 7'd1;
                default: ;
            endcase
            if (term) begin
                cyc_q <= 1'b0;
                if (!fixed_q) adr_q <= adr_q + 1'b1;
                if (fail_q == 2'd0) fail_q <= code;
                if (code == 2'd0 && nack_q != 6'h3f) nack_q <= nack_q + 6'd1;
                if (!wbwe_q) rdata_q <= (code == 2'd0) ? wb.dat_i : 8'h00;
            end else if (cyc_q) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (rx_ferr && (state_q == StAddr || state_q == StWrData)) cyc_q <= 1'b0;
        end
    end

    assign uart_txd = txd_q;
    assign wb.cyc_o = cyc_q;
    assign wb.stb_o = cyc_q;
    assign wb.adr_o = adr_q;
    assign wb.dat_o = dat_q;
    assign wb.we_o  = wbwe_q;
endmodule

// File: doc/uart2wb_burst.md
Name: uart2wb_burst

Overview:
- Parametrised successor of the single-transfer UART-to-Wishbone bridge.
- Takes framed commands from a host UART and issues single or burst Wishbone cycles, with auto-incrementing or fixed addressing.
- Returns read data plus a status byte over the UART TX line.
- Sits between the board UART pins and the design's Wishbone interconnect as the debug/test master.

Parameters:
- CLKS_PER_BIT, 16, clk_i cycles per UART bit; even, >= 4.
- ADDR_BYTES, 3, number of address bytes in a command (1..4); adr_o width = 8*ADDR_BYTES.
- TIMEOUT_CYCLES, 255, cycles waited for ack/err/rty before a cycle is aborted (>= 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- uart_rxd  in  1  UART receive, idle high, asynchronous to clk_i
- uart_txd  out  1  UART transmit, idle high
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe (always equal to cyc_o)
- adr_o  out  8*ADDR_BYTES  Wishbone address
- dat_o  out  8  Wishbone write data
- we_o  out  1  Wishbone write enable
- ack_i / err_i / rty_i  in  1  Wishbone terminations
- dat_i  in  8  Wishbone read data
- busy_o  out  1  high from first header byte received until the status byte stop bit completes

Behaviour:
- Reset values: uart_txd=1, cyc_o=stb_o=0, we_o=0, adr_o=0, dat_o=0, busy_o=0. Parser returns to expecting a header; all counters are cleared.
- Reset mid-frame or mid-cycle takes effect on the next edge; any in-flight Wishbone cycle drops immediately.
- UART format: 8N1, LSB first on both RX and TX.
- RX front end:
  - uart_rxd passes through a 2-flop synchroniser.
  - A start bit is a synchronised falling edge.
  - The start bit is re-checked at CLKS_PER_BIT/2; if the line is high there, it was a glitch and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that point.
  - The stop bit is sampled the same way; stop=0 is a framing error: the byte is discarded and the frame parser resets to expecting a header.
- Command frame:
  - Header byte: bit7 = we, bit6 = fixed (1: no address increment), bits[5:0] = N-1, so bursts are 1..64 transfers.
  - Then ADDR_BYTES address bytes, least significant byte first.
  - Write commands follow with N data bytes.
- Write burst:
  - Each data byte starts a cycle one clock after its stop-bit sample: cyc_o=stb_o=we_o=1, dat_o = the byte.
  - The next byte is received concurrently and buffered; the RX holding register is one byte deep.
- Read burst:
  - After the last address byte, a cycle starts with we_o=0.
  - On termination, dat_i is captured and transmitted.
  - The next read cycle starts the clock after that byte's TX stop bit ends.
- Termination:
  - A cycle ends on the first cycle with ack_i|err_i|rty_i, or when TIMEOUT_CYCLES cycles elapse with none.
  - cyc_o drops on the following edge.
  - If several terminations are asserted together, priority is err > rty > ack.
- Address:
  - adr_o increments by 1 after each transfer unless fixed=1.
  - The increment wraps modulo 2^(8*ADDR_BYTES).
- Failure handling:
  - After the first non-ack termination (err, rty or timeout), no further cycles are issued in the burst.
  - Remaining write bytes are still received and discarded.
  - Remaining read bytes are transmitted as 0x00.
- Status byte: sent after the last data transfer and reports the first failure in the burst.
  - 0x00 all ack, 0x01 err, 0x02 rty, 0x03 timeout.
  - bits[7:2] = number of completed acked transfers, saturating at 63.
- TX: start bit, 8 data bits, stop bit, each CLKS_PER_BIT cycles. uart_txd stays 1 between bytes.
- RX during response: bytes arriving while a read burst or the status byte is being sent are dropped without framing checks. The parser resumes with a header after the status byte.
- Top-level state machine: HEADER -> ADDR -> (WR_DATA | RD_CYCLE -> RD_TX) -> STATUS_TX -> HEADER.

Test Plan:
- Single write: CLKS_PER_BIT=16, send 0x80, 0x34, 0x12, 0x00, 0xA5, slave acks after 2 cycles -> one cycle with adr_o=0x001234, dat_o=0xA5, we_o=1; TX returns 0x04.
- Read burst, incrementing: send 0x03, 0x00, 0x10, 0x00 (N=4), slave returns 0x11, 0x22, 0x33, 0x44 -> adr_o 0x1000..0x1003 in order; TX 0x11, 0x22, 0x33, 0x44, then 0x10.
- Fixed-address write burst plus wrap: send 0xC1, 0xFF, 0xFF, 0xFF, then 0x01, 0x02 -> two cycles both at 0xFFFFFF. Repeat with header 0x81 -> second cycle at 0x000000. Status 0x08 in both cases.
- Error mid-burst: read N=3, slave asserts err_i together with ack_i on the 2nd transfer -> only 2 cycles issued; TX first byte, 0x00, 0x00, then status 0x05.
- Timeout: TIMEOUT_CYCLES=8, write with slave silent -> cyc_o high exactly 8 cycles then low; status 0x03.
- RX robustness: a 3-cycle low glitch on rxd produces no byte. A byte with stop bit 0 between header and address resets the parser, and a following valid command executes correctly. Asserting rst_i during an active cycle gives cyc_o=0 and uart_txd=1 on the next edge.
